// File: rtl/ctr_emitter_cc_if.sv
// Commit-side observation bus and record output bus of the CTR emitter.
// The commit stage drives the master side, the emitter is the slave.
interface ctr_emitter_cc_if #(
  parameter int unsigned NrCommitPorts = 2,
  parameter int unsigned XLEN = 64
);
  logic [NrCommitPorts*XLEN-1:0]     source_i;
  logic [NrCommitPorts*4-1:0]        type_i;
  logic [NrCommitPorts-1:0]          valid_i;
  logic [15:0]                       type_mask_i;
  logic                              freeze_i;
  logic                              flush_i;
  logic [NrCommitPorts-1:0]          rec_valid_o;
  logic [NrCommitPorts*(XLEN-1)-1:0] rec_source_o;
  logic [NrCommitPorts*(XLEN-1)-1:0] rec_target_o;
  logic [NrCommitPorts*4-1:0]        rec_type_o;
  logic [NrCommitPorts*16-1:0]       rec_cc_o;
  logic [NrCommitPorts-1:0]          rec_ccv_o;

  modport master (
    output source_i, type_i, valid_i,
    output type_mask_i, freeze_i, flush_i,
    input  rec_valid_o, rec_source_o, rec_target_o,
    input  rec_type_o, rec_cc_o, rec_ccv_o
  );

  modport slave (
    input  source_i, type_i, valid_i,
    input  type_mask_i, freeze_i, flush_i,
    output rec_valid_o, rec_source_o, rec_target_o,
    output rec_type_o, rec_cc_o, rec_ccv_o
  );
endinterface

// File: rtl/ctr_emitter_cc.sv
// Pairs retired control transfers with their targets and emits
// filtered CTR records carrying an encoded cycle count.
module ctr_emitter_cc #(
  parameter int unsigned NrCommitPorts = 2,
  parameter int unsigned XLEN = 64,
  parameter int unsigned CntWidth = 27
) (
  input  logic clk_i,
  input  logic rstn_i,
  ctr_emitter_cc_if.slave bus
);
  localparam int unsigned NP = NrCommitPorts;
  localparam int unsigned AW = XLEN - 1;
  localparam logic [CntWidth-1:0] CntMax = '1;

  typedef logic [AW-1:0] pc_t;
  typedef logic [3:0]    cft_t;

  logic [NP-1:0][XLEN-1:0] pc;
  cft_t [NP-1:0]           ty;
  logic                    unused_pc;

  logic                pend_v_q, pend_v_d;
  pc_t                 pend_src_q, pend_src_d;
  cft_t                pend_ty_q, pend_ty_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                armed_q, armed_d;

  logic [NP-1:0]       cv;
  pc_t [NP-1:0]        cs;
  cft_t [NP-1:0]       ct;
  logic [NP-1:0]       emit;

  logic [NP-1:0]        rv_q, rv_d;
  pc_t [NP-1:0]         rsrc_q, rsrc_d;
  pc_t [NP-1:0]         rtgt_q, rtgt_d;
  cft_t [NP-1:0]        rty_q, rty_d;
  logic [NP-1:0][15:0]  rcc_q, rcc_d;
  logic [NP-1:0]        rccv_q, rccv_d;

  assign pc = bus.source_i;
  assign ty = bus.type_i;
  // PC bit 0 is never recorded
  assign unused_pc = ^bus.source_i;

  // Pseudo-float CC: exponent above 12 bits, 12 mantissa bits below MSB
  function automatic logic [15:0] cc_enc(input logic [CntWidth-1:0] c);
    logic [15:0] r;
    r = {4'd0, c[11:0]};
    for (int p = 12; p < int'(CntWidth); p++) begin
      if (c[p]) r = {4'(p - 11), 12'(c >> (p - 12))};
    end
    return r;
  endfunction

  // Candidate transfers: pending into port 0, then port j-1 into port j
  always_comb begin
    cv = '0;
    cs = '0;
    ct = '0;
    cv[0] = pend_v_q & bus.valid_i[0];
    cs[0] = pend_src_q;
    ct[0] = pend_ty_q;
    for (int j = 1; j < int'(NP); j++) begin
      cv[j] = bus.valid_i[j] & (ty[j-1] != '0);
      cs[j] = pc[j-1][XLEN-1:1];
      ct[j] = ty[j-1];
    end
    for (int j = 0; j < int'(NP); j++) begin
      emit[j] = cv[j] & bus.type_mask_i[ct[j]] & ~bus.freeze_i;
    end
  end

  // Last valid port decides the new pending transfer; flush wins
  always_comb begin
    pend_v_d   = pend_v_q;
    pend_src_d = pend_src_q;
    pend_ty_d  = pend_ty_q;
    for (int j = 0; j < int'(NP); j++) begin
      if (bus.valid_i[j]) begin
        pend_v_d   = ty[j] != '0;
        pend_src_d = (ty[j] != '0) ? pc[j][XLEN-1:1] : '0;
        pend_ty_d  = ty[j];
      end
    end
    if (bus.flush_i) begin
      pend_v_d   = 1'b0;
      pend_src_d = '0;
      pend_ty_d  = '0;
    end
  end

  // Records for next cycle; only the lowest emitted slot carries the count
  always_comb begin
    logic first;
    first  = 1'b1;
    rv_d   = '0;
    rsrc_d = '0;
    rtgt_d = '0;
    rty_d  = '0;
    rcc_d  = '0;
    rccv_d = '0;
    for (int j = 0; j < int'(NP); j++) begin
      if (emit[j]) begin
        rv_d[j]   = 1'b1;
        rsrc_d[j] = cs[j];
        rtgt_d[j] = pc[j][XLEN-1:1];
        rty_d[j]  = ct[j];
        rcc_d[j]  = first ? cc_enc(cnt_q) : 16'h0;
        rccv_d[j] = first ? armed_q : 1'b1;
        first     = 1'b0;
      end
    end
  end

  // Saturating cycle counter, cleared on emission, held while frozen
  always_comb begin
    if (|emit) begin
      cnt_d = '0;
    end else if (bus.freeze_i || cnt_q == CntMax) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CntWidth'(1);
    end
    if (bus.freeze_i) begin
      armed_d = 1'b0;
    end else if (|emit) begin
      armed_d = 1'b1;
    end else begin
      armed_d = armed_q;
    end
  end

  // State and registered record outputs
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      pend_v_q   <= 1'b0;
      pend_src_q <= '0;
      pend_ty_q  <= '0;
      cnt_q      <= '0;
      armed_q    <= 1'b0;
      rv_q       <= '0;
      rsrc_q     <= '0;
      rtgt_q     <= '0;
      rty_q      <= '0;
      rcc_q      <= '0;
      rccv_q     <= '0;
    end else begin
      pend_v_q   <= pend_v_d;
      pend_src_q <= pend_src_d;
      pend_ty_q  <= pend_ty_d;
      cnt_q      <= cnt_d;
      armed_q    <= armed_d;
      rv_q       <= rv_d;
      rsrc_q     <= rsrc_d;
      rtgt_q     <= rtgt_d;
      rty_q      <= rty_d;
      rcc_q      <= rcc_d;
      rccv_q     <= rccv_d;
    end
  end

  assign bus.rec_valid_o  = rv_q;
  assign bus.rec_source_o = rsrc_q;
  assign bus.rec_target_o = rtgt_q;
  assign bus.rec_type_o   = rty_q;
  assign bus.rec_cc_o     = rcc_q;
  assign bus.rec_ccv_o    = rccv_q;

`ifndef SYNTHESIS
  logic [NP-1:0] vinc;
  assign vinc = bus.valid_i + NP'(1);
  valid_thermo_a: assert property (
    @(posedge clk_i) disable iff (!rstn_i)
    (vinc & bus.valid_i) == '0
  );
`endif
endmodule

// File: tb/tb_ctr_emitter_cc.sv
// Directed bench for ctr_emitter_cc: per-cycle model comparison
// plus literal checks on hand-computed records.
module tb_ctr_emitter_cc;
  localparam int NP = 2;
  localparam int XL = 64;
  localparam int AW = XL - 1;
  localparam int unsigned CMAX = (1 << 27) - 1;

  logic clk = 1'b0;
  logic rstn = 1'b1;
  int n_chk = 0;
  int n_pass = 0;

  ctr_emitter_cc_if #(.NrCommitPorts(NP), .XLEN(XL)) bus ();

  ctr_emitter_cc #(
    .NrCommitPorts(NP),
    .XLEN(XL),
    .CntWidth(27)
  ) dut (
    .clk_i(clk),
    .rstn_i(rstn),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  logic        m_pv;
  logic [63:0] m_ppc;
  logic [3:0]  m_pt;
  int unsigned m_cnt;
  logic        m_arm;

  logic [NP-1:0]          n_v, e_v;
  logic [NP-1:0][AW-1:0]  n_src, e_src, n_tgt, e_tgt;
  logic [NP-1:0][3:0]     n_ty, e_ty;
  logic [NP-1:0][15:0]    n_cc, e_cc;
  logic [NP-1:0]          n_ccv, e_ccv;

  function automatic logic [15:0] cc_enc(input int unsigned c);
    int unsigned m;
    int e;
    if (c < 4096) return 16'(c);
    m = c;
    e = 0;
    while (m >= 8192) begin
      m = m / 2;
      e++;
    end
    return {4'(e + 1), 12'(m - 4096)};
  endfunction

  task automatic model_reset();
    m_pv = 0; m_ppc = 0; m_pt = 0; m_cnt = 0; m_arm = 0;
    n_v = '0; n_src = '0; n_tgt = '0; n_ty = '0; n_cc = '0; n_ccv = '0;
    e_v = '0; e_src = '0; e_tgt = '0; e_ty = '0; e_cc = '0; e_ccv = '0;
  endtask

  // Walk the retired instructions in order, chaining each transfer
  task automatic model_step();
    logic pv, first, any;
    logic [63:0] ppc, pc;
    logic [3:0] pt, t;
    pv = m_pv; ppc = m_ppc; pt = m_pt;
    first = 1; any = 0;
    n_v = '0; n_src = '0; n_tgt = '0; n_ty = '0; n_cc = '0; n_ccv = '0;
    for (int i = 0; i < NP; i++) begin
      if (bus.valid_i[i]) begin
        pc = bus.source_i[i*XL +: XL];
        t = bus.type_i[i*4 +: 4];
        if (pv && bus.type_mask_i[pt] && !bus.freeze_i) begin
          n_v[i] = 1;
          n_src[i] = ppc[63:1];
          n_tgt[i] = pc[63:1];
          n_ty[i] = pt;
          n_cc[i] = first ? cc_enc(m_cnt) : 16'h0;
          n_ccv[i] = first ? m_arm : 1'b1;
          first = 0;
          any = 1;
        end
        pv = (t != 0); ppc = pc; pt = t;
      end
    end
    if (bus.flush_i) pv = 0;
    m_pv = pv; m_ppc = ppc; m_pt = pt;
    if (any) m_cnt = 0;
    else if (!bus.freeze_i && m_cnt < CMAX) m_cnt++;
    if (bus.freeze_i) m_arm = 0;
    else if (any) m_arm = 1;
  endtask

  task automatic tick();
    if (rstn) model_step();
    else begin
      n_v = '0; n_src = '0; n_tgt = '0; n_ty = '0; n_cc = '0; n_ccv = '0;
    end
    @(posedge clk);
    #1;
    e_v = n_v; e_src = n_src; e_tgt = n_tgt;
    e_ty = n_ty; e_cc = n_cc; e_ccv = n_ccv;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic ret(input logic [1:0] v,
                     input logic [63:0] p0, input logic [3:0] t0,
                     input logic [63:0] p1, input logic [3:0] t1);
    bus.valid_i = v;
    bus.source_i = {p1, p0};
    bus.type_i = {t1, t0};
    tick();
    bus.valid_i = '0;
    bus.source_i = '0;
    bus.type_i = '0;
  endtask

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
  endtask

  function automatic logic [63:0] src_s(input int s);
    return 64'(bus.rec_source_o[s*AW +: AW]);
  endfunction
  function automatic logic [63:0] tgt_s(input int s);
    return 64'(bus.rec_target_o[s*AW +: AW]);
  endfunction
  function automatic logic [63:0] cc_s(input int s);
    return 64'(bus.rec_cc_o[s*16 +: 16]);
  endfunction
  function automatic logic [63:0] ty_s(input int s);
    return 64'(bus.rec_type_o[s*4 +: 4]);
  endfunction

  task automatic compare_loop();
    forever begin
      @(negedge clk);
      n_chk++;
      if (bus.rec_valid_o === e_v && bus.rec_source_o === e_src &&
          bus.rec_target_o === e_tgt && bus.rec_type_o === e_ty &&
          bus.rec_cc_o === e_cc && bus.rec_ccv_o === e_ccv)
        n_pass++;
      else
        $display("FAIL cycle@%0t: v %b/%b cc %h/%h ccv %b/%b ty %h/%h src %h/%h tgt %h/%h",
                 $time, bus.rec_valid_o, e_v, bus.rec_cc_o, e_cc,
                 bus.rec_ccv_o, e_ccv, bus.rec_type_o, e_ty,
                 bus.rec_source_o, e_src, bus.rec_target_o, e_tgt);
    end
  endtask

  initial begin
    bus.valid_i = '0;
    bus.source_i = '0;
    bus.type_i = '0;
    bus.type_mask_i = 16'hFFFF;
    bus.freeze_i = 0;
    bus.flush_i = 0;
    model_reset();
    #3 rstn = 0;
    fork
      compare_loop();
    join_none
    idle(2);
    rstn = 1;
    chk("rst_valid", 64'(bus.rec_valid_o), 0);
    chk("rst_cc", 64'(bus.rec_cc_o), 0);

    // lone branch, target retires three cycles later
    ret(2'b01, 64'h1000, 4, 0, 0);
    idle(2);
    ret(2'b01, 64'h2000, 0, 0, 0);
    chk("t1_valid", 64'(bus.rec_valid_o), 64'h1);
    chk("t1_src", src_s(0), 64'h800);
    chk("t1_tgt", tgt_s(0), 64'h1000);
    chk("t1_type", ty_s(0), 64'h4);
    chk("t1_cc", cc_s(0), 64'h3);
    chk("t1_ccv", 64'(bus.rec_ccv_o[0]), 0);
    idle(1);
    chk("t1_once", 64'(bus.rec_valid_o), 0);

    // same-cycle pair
    idle(9);
    ret(2'b11, 64'h100, 5, 64'h400, 0);
    chk("t2_valid", 64'(bus.rec_valid_o), 64'h2);
    chk("t2_src", src_s(1), 64'h80);
    chk("t2_tgt", tgt_s(1), 64'h200);
    chk("t2_cc", cc_s(1), 64'h000A);
    chk("t2_ccv", 64'(bus.rec_ccv_o[1]), 1);

    // masked type keeps the counter running
    bus.type_mask_i = 16'hFFDF;
    ret(2'b11, 64'h100, 5, 64'h400, 0);
    chk("t3_masked", 64'(bus.rec_valid_o), 0);
    bus.type_mask_i = 16'hFFFF;
    idle(2);
    ret(2'b11, 64'h100, 5, 64'h400, 0);
    chk("t3_cnt", cc_s(1), 64'h3);

    // flush discards pending
    ret(2'b01, 64'h1000, 4, 0, 0);
    bus.flush_i = 1;
    tick();
    bus.flush_i = 0;
    ret(2'b01, 64'h3000, 0, 0, 0);
    chk("t4_flush", 64'(bus.rec_valid_o), 0);
    ret(2'b01, 64'h500, 4, 0, 0);
    bus.flush_i = 1;
    ret(2'b01, 64'h600, 0, 0, 0);
    bus.flush_i = 0;
    chk("t4_same_v", 64'(bus.rec_valid_o), 64'h1);
    chk("t4_same_src", src_s(0), 64'h280);
    chk("t4_same_cc", cc_s(0), 64'h4);
    bus.flush_i = 1;
    ret(2'b01, 64'h700, 3, 0, 0);
    bus.flush_i = 0;
    ret(2'b01, 64'h800, 0, 0, 0);
    chk("t4_load", 64'(bus.rec_valid_o), 0);

    // counter encoding
    ret(2'b11, 64'h100, 5, 64'h400, 0);
    idle(5000);
    ret(2'b11, 64'h100, 5, 64'h400, 0);
    chk("t5_cc5000", cc_s(1), 64'h1388);
    idle(20000);
    ret(2'b11, 64'h100, 5, 64'h400, 0);
    chk("t5_cc20000", cc_s(1), 64'h3388);
    ret(2'b01, 64'h40, 4, 0, 0);
    idle(3);
    ret(2'b11, 64'h50, 2, 64'h60, 0);
    chk("t5_two_v", 64'(bus.rec_valid_o), 64'h3);
    chk("t5_two_cc0", cc_s(0), 64'h4);
    chk("t5_two_cc1", cc_s(1), 64'h0);
    chk("t5_two_ccv", 64'(bus.rec_ccv_o), 64'h3);

    // freeze for 50 cycles
    ret(2'b01, 64'h1000, 4, 0, 0);
    bus.freeze_i = 1;
    ret(2'b01, 64'h2000, 0, 0, 0);
    ret(2'b01, 64'h3000, 4, 0, 0);
    idle(48);
    chk("t6_frozen", 64'(bus.rec_valid_o), 0);
    bus.freeze_i = 0;
    ret(2'b01, 64'h4000, 0, 0, 0);
    chk("t6_valid", 64'(bus.rec_valid_o), 64'h1);
    chk("t6_src", src_s(0), 64'h1800);
    chk("t6_cc", cc_s(0), 64'h1);
    chk("t6_ccv", 64'(bus.rec_ccv_o[0]), 0);

    // asynchronous reset mid-stream
    ret(2'b11, 64'h100, 5, 64'h400, 4);
    #2 rstn = 0;
    #1;
    chk("t7_async_v", 64'(bus.rec_valid_o), 0);
    chk("t7_async_src", 64'(bus.rec_source_o), 0);
    model_reset();
    idle(2);
    rstn = 1;
    ret(2'b01, 64'h900, 0, 0, 0);
    chk("t7_pend", 64'(bus.rec_valid_o), 0);
    ret(2'b11, 64'h100, 5, 64'h400, 0);
    chk("t7_ccv", 64'(bus.rec_ccv_o[1]), 0);
    chk("t7_cc", cc_s(1), 64'h1);
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
